mic_sample_framer: RTL and testbench

Parametrised multi-channel successor to the single-channel microphone capture stage. It takes raw unsigned ADC words on a sample strobe and averages 2^AVG_LOG2 samples per channel. Each average is converted to signed, midscale-centred values and widened to OUT_W. Result vectors are buffered in a FIFO and streamed out with valid/ready, plus a frame-boundary flag for the downstream FFT/visualiser.

---
 rtl/mic_sample_framer.sv | 227 ++++++++++++++++++++++
 tb/tb_mic_sample_framer.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mic_sample_framer.sv
// mic_sample_framer
//
// Multi-channel microphone capture stage. Raw unsigned ADC words arrive on a
// one-cycle sample strobe; 2^AVG_LOG2 samples per channel are summed and
// averaged. Each average is re-centred around midscale to a signed value,
// widened to OUT_W (left-justified or sign-extended), and the resulting vector
// is queued in a show-ahead FIFO and streamed out with valid/ready. Each
// queued vector carries a frame-boundary flag every FRAME_LEN accepted vectors.
//
// Ports:
//   sampling_clk  sole clock, rising edge
//   rst           synchronous reset, active-high
//   capture_en    gates accumulation; low for a cycle discards a partial average
//   sample_tick   one-cycle strobe qualifying adc_data
//   adc_data      NUM_CH raw unsigned samples, channel 0 in the LSBs
//   out_valid     FIFO head vector available
//   out_ready     downstream accepts the head vector
//   out_data      NUM_CH signed samples, channel 0 in the LSBs
//   out_last      head vector is the last of a frame
//   fifo_level    vectors currently stored
//   overflow      sticky: a completed vector was dropped on a full FIFO

module mic_sample_framer #(
  parameter int NUM_CH     = 2,
  parameter int ADC_W      = 12,
  parameter int OUT_W      = 16,
  parameter int AVG_LOG2   = 2,
  parameter int JUSTIFY    = 1,
  parameter int FIFO_DEPTH = 4,
  parameter int FRAME_LEN  = 8
) (
  input  logic                              sampling_clk,
  input  logic                              rst,
  input  logic                              capture_en,
  input  logic                              sample_tick,
  input  logic [NUM_CH*ADC_W-1:0]           adc_data,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [NUM_CH*OUT_W-1:0]           out_data,
  output logic                              out_last,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level,
  output logic                              overflow
);

  localparam int ACC_W = ADC_W + AVG_LOG2;
  localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = $clog2(FIFO_DEPTH + 1);
  localparam int FR_W  = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam int VEC_W = NUM_CH * OUT_W;

  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'((1 << AVG_LOG2) - 1);
  localparam logic [FR_W-1:0]  FRAME_LAST = FR_W'(FRAME_LEN - 1);
  localparam logic [LVL_W-1:0] LVL_FULL   = LVL_W'(FIFO_DEPTH);

  // ---------------------------------------------------------------------------
  // Averaging control
  // ---------------------------------------------------------------------------
  logic             accept;
  logic             complete;
  logic [CNT_W-1:0] avg_cnt_reg;
  logic [CNT_W-1:0] avg_cnt_next;

  assign accept   = capture_en & sample_tick;
  // With AVG_LOG2 = 0 the counter is pinned at 0 and every tick completes.
  assign complete = accept && (avg_cnt_reg == CNT_LAST);

  always_comb begin
    avg_cnt_next = avg_cnt_reg;
    if (!capture_en || complete) begin
      avg_cnt_next = '0;
    end else if (accept) begin
      avg_cnt_next = avg_cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge sampling_clk) begin
    if (rst) begin
      avg_cnt_reg <= '0;
    end else begin
      avg_cnt_reg <= avg_cnt_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Per-channel accumulate, average, centre and widen
  // ---------------------------------------------------------------------------
  logic [VEC_W-1:0] push_vec;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [ADC_W-1:0] sample;
      logic [ACC_W-1:0] acc_reg;
      logic [ACC_W-1:0] acc_next;
      logic [ACC_W-1:0] sum;
      logic [ADC_W-1:0] avg;
      logic [ADC_W-1:0] centred;

      assign sample = adc_data[gi*ADC_W +: ADC_W];
      // Accumulator is sized for 2^AVG_LOG2 full-scale samples, so no carry-out.
      assign sum    = acc_reg + ACC_W'(sample);
      // Upper ADC_W bits of the sum are the truncated average.
      assign avg    = sum[ACC_W-1 -: ADC_W];
      // Subtracting midscale in ADC_W-bit two's complement is an MSB flip.
      assign centred = {~avg[ADC_W-1], avg[ADC_W-2:0]};

      always_comb begin
        acc_next = acc_reg;
        if (!capture_en || complete) begin
          acc_next = '0;
        end else if (accept) begin
          acc_next = sum;
        end
      end

      always_ff @(posedge sampling_clk) begin
        if (rst) begin
          acc_reg <= '0;
        end else begin
          acc_reg <= acc_next;
        end
      end

      if (OUT_W == ADC_W) begin : g_same
        assign push_vec[gi*OUT_W +: OUT_W] = centred;
      end else if (JUSTIFY != 0) begin : g_left
        assign push_vec[gi*OUT_W +: OUT_W] = {centred, {(OUT_W-ADC_W){1'b0}}};
      end else begin : g_sext
        assign push_vec[gi*OUT_W +: OUT_W] = {{(OUT_W-ADC_W){centred[ADC_W-1]}}, centred};
      end
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Output FIFO with registered show-ahead head
  // ---------------------------------------------------------------------------
  logic [VEC_W:0]     mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0]   rd_ptr_reg, rd_ptr_next;
  logic [LVL_W-1:0]   level_reg, level_next;
  logic [FR_W-1:0]    frame_cnt_reg, frame_cnt_next;
  logic [VEC_W:0]     head_reg, head_next;
  logic               overflow_reg, overflow_next;
  logic               pop;
  logic               full;
  logic               push_ok;
  logic [VEC_W:0]     push_word;

  assign pop       = (level_reg != '0) && out_ready;
  assign full      = (level_reg == LVL_FULL);
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push_ok   = complete && (!full || pop);
  assign push_word = {(frame_cnt_reg == FRAME_LAST), push_vec};

  always_comb begin
    level_next     = level_reg;
    wr_ptr_next    = wr_ptr_reg;
    rd_ptr_next    = rd_ptr_reg;
    frame_cnt_next = frame_cnt_reg;
    overflow_next  = overflow_reg;
    head_next      = head_reg;

    if (push_ok && !pop) begin
      level_next = level_reg + 1'b1;
    end else if (!push_ok && pop) begin
      level_next = level_reg - 1'b1;
    end

    if (push_ok) begin
      wr_ptr_next    = wr_ptr_reg + 1'b1;
      frame_cnt_next = (frame_cnt_reg == FRAME_LAST) ? '0 : frame_cnt_reg + 1'b1;
    end

    if (pop) begin
      rd_ptr_next = rd_ptr_reg + 1'b1;
    end

    if (complete && full && !pop) begin
      overflow_next = 1'b1;
    end

    // Load the next head so out_data is valid the cycle out_valid rises. If
    // the new read pointer lands on the slot being written right now, the
    // head is the incoming vector rather than the (stale) array contents.
    // An empty FIFO keeps the previous head on the outputs.
    if (level_next != '0) begin
      if (push_ok && (rd_ptr_next == wr_ptr_reg)) begin
        head_next = push_word;
      end else begin
        head_next = mem[rd_ptr_next];
      end
    end
  end

  always_ff @(posedge sampling_clk) begin
    if (rst) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      level_reg     <= '0;
      frame_cnt_reg <= '0;
      overflow_reg  <= 1'b0;
      head_reg      <= '0;
    end else begin
      wr_ptr_reg    <= wr_ptr_next;
      rd_ptr_reg    <= rd_ptr_next;
      level_reg     <= level_next;
      frame_cnt_reg <= frame_cnt_next;
      overflow_reg  <= overflow_next;
      head_reg      <= head_next;
    end
  end

  // Storage array carries no reset; pointers define which slots are live.
  always_ff @(posedge sampling_clk) begin
    if (!rst && push_ok) begin
      mem[wr_ptr_reg] <= push_word;
    end
  end

  assign out_valid  = (level_reg != '0);
  assign out_data   = head_reg[VEC_W-1:0];
  assign out_last   = head_reg[VEC_W];
  assign fifo_level = level_reg;
  assign overflow   = overflow_reg;

endmodule

// File: tb/tb_mic_sample_framer.sv
// Testbench for mic_sample_framer. Two instances share all stimulus: one
// left-justified, one sign-extended. Expected vectors are queued when the
// completing tick is driven and compared when each instance pops its head.

module tb_mic_sample_framer;

  logic        sampling_clk = 1'b0;
  logic        rst;
  logic        capture_en;
  logic        sample_tick;
  logic [23:0] adc_data;
  logic        out_ready;

  logic        out_valid_j1, out_last_j1, overflow_j1;
  logic [31:0] out_data_j1;
  logic [2:0]  fifo_level_j1;
  logic        out_valid_j0, out_last_j0, overflow_j0;
  logic [31:0] out_data_j0;
  logic [2:0]  fifo_level_j0;

  always #5 sampling_clk = ~sampling_clk;

  mic_sample_framer #(.JUSTIFY(1)) dut_j1 (
    .sampling_clk (sampling_clk),
    .rst          (rst),
    .capture_en   (capture_en),
    .sample_tick  (sample_tick),
    .adc_data     (adc_data),
    .out_valid    (out_valid_j1),
    .out_ready    (out_ready),
    .out_data     (out_data_j1),
    .out_last     (out_last_j1),
    .fifo_level   (fifo_level_j1),
    .overflow     (overflow_j1)
  );

  mic_sample_framer #(.JUSTIFY(0)) dut_j0 (
    .sampling_clk (sampling_clk),
    .rst          (rst),
    .capture_en   (capture_en),
    .sample_tick  (sample_tick),
    .adc_data     (adc_data),
    .out_valid    (out_valid_j0),
    .out_ready    (out_ready),
    .out_data     (out_data_j0),
    .out_last     (out_last_j0),
    .fifo_level   (fifo_level_j0),
    .overflow     (overflow_j0)
  );

  typedef struct {
    logic [31:0] data;
    logic        last;
  } exp_t;

  exp_t        q_j1[$];
  exp_t        q_j0[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          acc_cnt  = 0;
  int          sum0     = 0;
  int          sum1     = 0;
  int          frame_idx = 0;
  bit          drop_next = 1'b0;
  logic [31:0] last_j1 = '0;
  logic [31:0] last_j0 = '0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: average of four, minus midscale, then widen.
  function automatic logic [15:0] exp_ch(input int sum, input bit just);
    int         avg;
    logic [11:0] c;
    avg = sum / 4;
    c   = 12'(avg - 2048);
    return just ? {c, 4'h0} : {{4{c[11]}}, c};
  endfunction

  // One accepted tick; the fourth one of an average queues the expectation.
  task automatic tick(input logic [11:0] c0, input logic [11:0] c1);
    exp_t e;
    sample_tick = 1'b1;
    adc_data    = {c1, c0};
    sum0 += int'(c0);
    sum1 += int'(c1);
    acc_cnt++;
    if (acc_cnt == 4) begin
      if (!drop_next) begin
        e.last = ((frame_idx % 8) == 7);
        frame_idx++;
        e.data = {exp_ch(sum1, 1'b1), exp_ch(sum0, 1'b1)};
        q_j1.push_back(e);
        e.data = {exp_ch(sum1, 1'b0), exp_ch(sum0, 1'b0)};
        q_j0.push_back(e);
      end
      acc_cnt = 0;
      sum0    = 0;
      sum1    = 0;
    end
    @(posedge sampling_clk); #1;
    sample_tick = 1'b0;
  endtask

  task automatic avg4(input logic [11:0] c0, input logic [11:0] c1);
    repeat (4) tick(c0, c1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge sampling_clk); #1;
    end
  endtask

  task automatic abort_cycle();
    capture_en = 1'b0;
    idle(1);
    capture_en = 1'b1;
    acc_cnt = 0;
    sum0    = 0;
    sum1    = 0;
  endtask

  // Reset held for three cycles while ticks are active.
  task automatic do_reset();
    rst         = 1'b1;
    capture_en  = 1'b1;
    sample_tick = 1'b1;
    adc_data    = 24'h5A3_C71;
    idle(3);
    rst         = 1'b0;
    sample_tick = 1'b0;
    acc_cnt   = 0;
    sum0      = 0;
    sum1      = 0;
    frame_idx = 0;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    out_ready = 1'b1;
    while ((q_j1.size() != 0 || q_j0.size() != 0) && n < 200) begin
      idle(1);
      n++;
    end
    check_eq({tag, "_drained"}, 64'(q_j1.size() + q_j0.size()), 64'd0);
    @(negedge sampling_clk);
    check_eq({tag, "_empty_valid"}, out_valid_j1, 1'b0);
    check_eq({tag, "_hold_data"}, out_data_j1, last_j1);
    @(posedge sampling_clk); #1;
  endtask

  always @(negedge sampling_clk) begin : mon_j1
    exp_t e;
    if (!rst && out_valid_j1 && out_ready) begin
      if (q_j1.size() == 0) begin
        check_eq("j1_spurious_vec", 64'(q_j1.size()), 64'd1);
      end else begin
        e = q_j1.pop_front();
        $display("j1 vec ch0=0x%04h ch1=0x%04h last=%0d", out_data_j1[15:0], out_data_j1[31:16], out_last_j1);
        check_eq("j1_data", out_data_j1, e.data);
        check_eq("j1_last", out_last_j1, e.last);
        last_j1 = out_data_j1;
      end
    end
  end

  always @(negedge sampling_clk) begin : mon_j0
    exp_t e;
    if (!rst && out_valid_j0 && out_ready) begin
      if (q_j0.size() == 0) begin
        check_eq("j0_spurious_vec", 64'(q_j0.size()), 64'd1);
      end else begin
        e = q_j0.pop_front();
        $display("j0 vec ch0=0x%04h ch1=0x%04h last=%0d", out_data_j0[15:0], out_data_j0[31:16], out_last_j0);
        check_eq("j0_data", out_data_j0, e.data);
        check_eq("j0_last", out_last_j0, e.last);
        last_j0 = out_data_j0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst         = 1'b1;
    capture_en  = 1'b0;
    sample_tick = 1'b0;
    adc_data    = '0;
    out_ready   = 1'b1;
    idle(1);

    // Reset with ticks active.
    do_reset();
    rst = 1'b1;
    @(negedge sampling_clk);
    check_eq("rst_valid", out_valid_j1, 1'b0);
    check_eq("rst_data_j1", out_data_j1, 32'h0);
    check_eq("rst_data_j0", out_data_j0, 32'h0);
    check_eq("rst_last", out_last_j1, 1'b0);
    check_eq("rst_level", fifo_level_j1, 3'd0);
    check_eq("rst_overflow", overflow_j1, 1'b0);
    @(posedge sampling_clk); #1;
    rst = 1'b0;

    // Centering: three ticks must not produce a vector.
    tick(12'hFFF, 12'h000);
    tick(12'hFFF, 12'h000);
    tick(12'hFFF, 12'h000);
    idle(2);
    @(negedge sampling_clk);
    check_eq("no_early_push_valid", out_valid_j1, 1'b0);
    check_eq("no_early_push_level", fifo_level_j1, 3'd0);
    @(posedge sampling_clk); #1;
    tick(12'hFFF, 12'h000);
    drain("center");

    // Midscale maps to zero.
    avg4(12'h800, 12'h800);
    drain("midscale");

    // Truncation and push latency.
    out_ready = 1'b0;
    tick(12'h800, 12'h000);
    tick(12'h801, 12'h001);
    tick(12'h801, 12'h002);
    @(negedge sampling_clk);
    check_eq("lat_before", out_valid_j1, 1'b0);
    @(posedge sampling_clk); #1;
    tick(12'h801, 12'h003);
    @(negedge sampling_clk);
    check_eq("lat_after", out_valid_j1, 1'b1);
    check_eq("lat_level", fifo_level_j1, 3'd1);
    @(posedge sampling_clk); #1;
    drain("trunc");

    // Abort a partial average.
    tick(12'h123, 12'h456);
    tick(12'h123, 12'h456);
    abort_cycle();
    avg4(12'hC00, 12'hC00);
    drain("abort");

    // Backpressure with a dropped fifth vector.
    out_ready = 1'b0;
    for (int v = 1; v <= 5; v++) begin
      drop_next = (v == 5);
      avg4(12'(2048 + v * 4), 12'(2048 - v * 4));
    end
    drop_next = 1'b0;
    @(negedge sampling_clk);
    check_eq("ovf_level_j1", fifo_level_j1, 3'd4);
    check_eq("ovf_level_j0", fifo_level_j0, 3'd4);
    check_eq("ovf_flag", overflow_j1, 1'b1);
    @(posedge sampling_clk); #1;
    drain("ovf");
    check_eq("ovf_sticky", overflow_j1, 1'b1);

    // Full FIFO with a simultaneous pop accepts the push.
    do_reset();
    @(negedge sampling_clk);
    check_eq("rst_clears_ovf", overflow_j1, 1'b0);
    @(posedge sampling_clk); #1;
    out_ready = 1'b0;
    for (int v = 6; v <= 9; v++) begin
      avg4(12'(2048 + v * 4), 12'(2048 - v * 4));
    end
    tick(12'h900, 12'h700);
    tick(12'h900, 12'h700);
    tick(12'h900, 12'h700);
    out_ready = 1'b1;
    tick(12'h900, 12'h700);
    @(negedge sampling_clk);
    check_eq("simul_overflow", overflow_j1, 1'b0);
    check_eq("simul_level", fifo_level_j1, 3'd4);
    @(posedge sampling_clk); #1;
    drain("simul");

    // Framing over 17 vectors.
    do_reset();
    out_ready = 1'b1;
    for (int v = 0; v < 17; v++) begin
      avg4(12'(v * 200), 12'(4095 - v * 100));
    end
    drain("frame");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
